// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path: default bit timing and the
// state encoding used by the transmit arbiter. The Transmitter and any future
// receiver import the same defaults so their dividers cannot drift apart.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Default bit timing; the divider must match the Transmitter's divider.
    localparam int CLKS_PER_BIT_DEFAULT = 5208;
    localparam int FRAME_BITS_DEFAULT   = 10;   // start + 8 data + stop

    // Arbiter state encoding, kept as plain constants for legacy tools.
    typedef logic [1:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 2'd0;
    localparam uart_state_t ST_START = 2'd1;
    localparam uart_state_t ST_SEND  = 2'd2;
    localparam uart_state_t ST_GAP   = 2'd3;

endpackage

// File: rtl/rr_priority_pick.sv
// -----------------------------------------------------------------------------
// rr_priority_pick
// Combinational round-robin selector. Returns the first asserted request found
// when searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
// Ports:
//   req     in   NUM_REQ          request vector
//   rr_ptr  in   $clog2(NUM_REQ)  index with highest priority this round
//   valid   out  1                at least one request is asserted
//   idx     out  $clog2(NUM_REQ)  selected requester (0 when valid is low)
// -----------------------------------------------------------------------------
module rr_priority_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic                       valid,
    output logic [$clog2(NUM_REQ)-1:0] idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int pos;

    // Walk the search order backwards so the nearest request to rr_ptr is
    // the last one written and therefore wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[pos[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin arbiter sharing one UART Transmitter among NUM_REQ byte sources.
// A granted byte is latched and handed to the Transmitter with a one-cycle
// strobe; the grant is then held for one full frame plus GAP_BITS idle bit
// times, counted locally so no busy feedback from the Transmitter is needed.
// Ports:
//   clk       in   1                system clock
//   rst_n     in   1                asynchronous active-low reset
//   req       in   NUM_REQ          per-source level request, held until ack
//   req_data  in   NUM_REQ*DATA_W   byte of source i at [i*DATA_W +: DATA_W]
//   ack       out  NUM_REQ          one-cycle pulse: byte of source i accepted
//   tx_start  out  1                one-cycle strobe to Transmitter.Transmit
//   tx_data   out  DATA_W           byte to Transmitter.data, held for the frame
//   busy      out  1                high whenever the FSM is not idle
//   grant_id  out  $clog2(NUM_REQ)  current or most recent granted source
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FRAME_BITS   = FRAME_BITS_DEFAULT,
    parameter int GAP_BITS     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        tx_start,
    output logic [DATA_W-1:0]           tx_data,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IDX_W      = $clog2(NUM_REQ);
    localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
    localparam int GAP_CLKS   = CLKS_PER_BIT * GAP_BITS;
    localparam int CNT_W      = (FRAME_CLKS > 1) ? $clog2(FRAME_CLKS) : 1;

    localparam logic [CNT_W-1:0]   FRAME_LOAD = CNT_W'(FRAME_CLKS - 1);
    localparam logic [CNT_W-1:0]   GAP_LOAD   = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [NUM_REQ-1:0] REQ_ONE    = NUM_REQ'(1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_REQ - 1);

    // The shared counter is sized for the frame; a longer gap cannot be held.
    if (GAP_CLKS > FRAME_CLKS) begin : g_gap_too_wide
        $error("uart_tx_arbiter: GAP_BITS*CLKS_PER_BIT exceeds the frame counter range");
    end
    if (NUM_REQ < 2) begin : g_too_few_req
        $error("uart_tx_arbiter: NUM_REQ must be at least 2");
    end

    uart_state_t        state;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   rr_ptr;
    logic               pick_vld;
    logic [IDX_W-1:0]   pick_idx;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .idx    (pick_idx)
    );

    // The frame counter is loaded on the grant edge and already counts during
    // START, so START plus SEND span exactly one frame measured from tx_start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            ack      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            grant_id <= '0;
        end else begin
            ack      <= '0;
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        tx_data  <= req_data[pick_idx*DATA_W +: DATA_W];
                        grant_id <= pick_idx;
                        ack      <= REQ_ONE << pick_idx;
                        tx_start <= 1'b1;
                        cnt      <= FRAME_LOAD;
                        busy     <= 1'b1;
                        state    <= ST_START;
                    end
                end
                ST_START: begin
                    cnt    <= cnt - CNT_ONE;
                    rr_ptr <= (grant_id == IDX_LAST) ? '0 : grant_id + IDX_ONE;
                    state  <= ST_SEND;
                end
                ST_SEND: begin
                    if (cnt == '0) begin
                        if (GAP_BITS == 0) begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= GAP_LOAD;
                            state <= ST_GAP;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int CPB     = 4;
    localparam int FB      = 10;
    localparam int GB      = 1;
    localparam int PERIOD  = 1 + CPB * (FB + GB);   // 45
    localparam int PERIOD0 = 1 + CPB * FB;          // 41 with no gap

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0, req2 = '0;
    logic [31:0] req_data = '0, req_data2 = '0;
    logic [3:0]  ack, ack2;
    logic        tx_start, tx_start2, busy, busy2;
    logic [7:0]  tx_data, tx_data2;
    logic [1:0]  grant_id, grant_id2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CLKS_PER_BIT(CPB),
        .FRAME_BITS(FB), .GAP_BITS(GB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .grant_id(grant_id)
    );

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .CLKS_PER_BIT(CPB),
        .FRAME_BITS(FB), .GAP_BITS(0)
    ) dut_nogap (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_data(req_data2),
        .ack(ack2), .tx_start(tx_start2), .tx_data(tx_data2),
        .busy(busy2), .grant_id(grant_id2)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  ack;
        logic [1:0]  gid;
        logic [7:0]  tx_byte;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        req2  = '0;
        repeat (2) tick();
        chk("reset_outs", {ack, tx_start, busy, grant_id, tx_data}, 32'h0);
        chk("reset_outs_nogap", {ack2, tx_start2, busy2, grant_id2, tx_data2}, 32'h0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || busy2) && n < 200) begin
            tick();
            n++;
        end
        chk(name, {31'd0, busy | busy2}, 32'd0);
    endtask

    vec_t vecs[10];

    // Random-test state
    logic [3:0] src_req;
    logic [7:0] src_byte [4];
    int         next_dec, g_cyc, e, n, bcnt, prev;
    logic [1:0] m_ptr, m_gid;
    logic [7:0] m_data;
    logic [3:0] exp_ack;
    logic       exp_busy, exp_start;
    int         rnd_err_before;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        // Table: rotation pointer evolves from 0 after reset
        vecs[0] = '{4'b0001, 32'h000000A5, 4'b0001, 2'd0, 8'hA5};
        vecs[1] = '{4'b1111, 32'h44332211, 4'b0010, 2'd1, 8'h22};
        vecs[2] = '{4'b0101, 32'h44332211, 4'b0100, 2'd2, 8'h33};
        vecs[3] = '{4'b1001, 32'h44332211, 4'b1000, 2'd3, 8'h44};
        vecs[4] = '{4'b1001, 32'h44332211, 4'b0001, 2'd0, 8'h11};
        vecs[5] = '{4'b1100, 32'h44332211, 4'b0100, 2'd2, 8'h33};
        vecs[6] = '{4'b0011, 32'h44332211, 4'b0001, 2'd0, 8'h11};
        vecs[7] = '{4'b0010, 32'h44332211, 4'b0010, 2'd1, 8'h22};
        vecs[8] = '{4'b1000, 32'h44332211, 4'b1000, 2'd3, 8'h44};
        vecs[9] = '{4'b0100, 32'h44332211, 4'b0100, 2'd2, 8'h33};

        do_reset();
        for (int i = 0; i < 10; i++) begin
            req      = vecs[i].req;
            req_data = vecs[i].data;
            tick();
            chk("vec_ack", {28'd0, ack}, {28'd0, vecs[i].ack});
            chk("vec_start", {31'd0, tx_start}, 32'd1);
            chk("vec_gid", {30'd0, grant_id}, {30'd0, vecs[i].gid});
            chk("vec_data", {24'd0, tx_data}, {24'd0, vecs[i].tx_byte});
            req = '0;
            n = 0;
            while (busy && n < 200) begin
                tick();
                n++;
            end
            chk("vec_busy_len", n, PERIOD - 1);
        end

        // All four requesting: strict rotation, fixed period
        do_reset();
        req      = 4'b1111;
        req_data = 32'h44332211;
        prev     = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (!tx_start && n < 100) begin
                tick();
                n++;
            end
            chk("rot_seen", {31'd0, tx_start}, 32'd1);
            chk("rot_gid", {30'd0, grant_id}, k % 4);
            chk("rot_data", {24'd0, tx_data}, ((k % 4) + 1) * 32'h11);
            if (k > 0) chk("rot_period", cyc - prev, PERIOD);
            prev = cyc;
            tick();
        end
        req = '0;
        wait_idle("rot_idle");

        // Request raised mid-frame waits; tx_data holds for the frame
        req      = 4'b0001;
        req_data = 32'h000000A5;
        tick();
        chk("mid_first_ack", {28'd0, ack}, 32'h1);
        prev = cyc;
        req  = '0;
        repeat (10) tick();
        req      = 4'b0100;
        req_data = 32'h005C0000;
        n = 0;
        while (!tx_start && n < 100) begin
            chk("mid_hold", {ack, tx_data}, {4'd0, 8'hA5});
            tick();
            n++;
        end
        chk("mid_ack", {28'd0, ack}, 32'h4);
        chk("mid_gid", {30'd0, grant_id}, 32'd2);
        chk("mid_data", {24'd0, tx_data}, 32'h5C);
        chk("mid_period", cyc - prev, PERIOD);
        req = '0;
        wait_idle("mid_idle");

        // Asynchronous reset in the middle of SEND, then pointer back at 0
        do_reset();
        req      = 4'b0100;
        req_data = 32'h44332211;
        tick();
        chk("rst_pre_gid", {30'd0, grant_id}, 32'd2);
        req = '0;
        repeat (20) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async", {ack, tx_start, busy, grant_id, tx_data}, 32'h0);
        tick();
        rst_n    = 1'b1;
        req      = 4'b1001;
        tick();
        chk("rst_after_ack", {28'd0, ack}, 32'h1);
        chk("rst_after_data", {tx_start, tx_data}, {1'b1, 8'h11});
        req = '0;
        wait_idle("rst_idle");

        // No gap: back-to-back frames from one held source
        req2      = 4'b0010;
        req_data2 = 32'h00007700;
        n = 0;
        while (!tx_start2 && n < 100) begin
            tick();
            n++;
        end
        chk("nogap_first", {31'd0, tx_start2}, 32'd1);
        prev = cyc;
        for (int k = 0; k < 3; k++) begin
            bcnt = 0;
            n = 0;
            do begin
                if (busy2) bcnt++;
                tick();
                n++;
            end while (!tx_start2 && n < 100);
            chk("nogap_seen", {31'd0, tx_start2}, 32'd1);
            chk("nogap_period", cyc - prev, PERIOD0);
            chk("nogap_busy", bcnt, PERIOD0 - 1);
            chk("nogap_out", {ack2, grant_id2, tx_data2}, {4'b0010, 2'd1, 8'h77});
            prev = cyc;
        end
        req2 = '0;
        wait_idle("nogap_idle");

        // Randomized traffic against a transaction-level model
        do_reset();
        src_req  = '0;
        for (int i = 0; i < 4; i++) src_byte[i] = '0;
        next_dec = 0;
        g_cyc    = -1000;
        m_ptr    = '0;
        m_gid    = '0;
        m_data   = '0;
        rnd_err_before = errors;
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < 4; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(3) != 0) src_req[i] = 1'b0;
                end else if (!src_req[i]) begin
                    if ($urandom_range(7) == 0) begin
                        src_req[i]  = 1'b1;
                        src_byte[i] = 8'($urandom);
                    end
                end else if ($urandom_range(63) == 0) begin
                    src_req[i] = 1'b0;
                end
            end
            req      = src_req;
            req_data = {src_byte[3], src_byte[2], src_byte[1], src_byte[0]};
            e = cyc + 1;
            if (e >= next_dec && req != 4'd0) begin
                for (int k = 3; k >= 0; k--) begin
                    if (req[(int'(m_ptr) + k) % 4]) m_gid = 2'((int'(m_ptr) + k) % 4);
                end
                m_data   = src_byte[m_gid];
                g_cyc    = e;
                next_dec = e + PERIOD;
                m_ptr    = 2'((int'(m_gid) + 1) % 4);
            end
            tick();
            exp_start = (cyc == g_cyc);
            exp_ack   = exp_start ? (4'b0001 << m_gid) : 4'b0000;
            exp_busy  = (cyc >= g_cyc) && (cyc < g_cyc + PERIOD - 1);
            chk("rand_outs", {16'd0, ack, tx_start, busy, grant_id, tx_data},
                {16'd0, exp_ack, exp_start, exp_busy, m_gid, m_data});
            if (errors - rnd_err_before > 10) break;
        end
        req = '0;
        wait_idle("rand_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
